spu_fetch_unit: RTL and testbench

//  Instruction-fetch stage of the dual-issue SPU pipeline; directly feeds the IF/ID register.

---
 rtl/spu_pkg.sv | 22 ++
 rtl/spu_fetch_skid.sv | 45 ++++
 rtl/spu_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_spu_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU instruction-fetch slice.
package spu_pkg;

  localparam logic [31:0] SPU_NOP  = 32'h4020_0000;
  localparam logic [31:0] SPU_LNOP = 32'h0020_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // slot0 is the even (first) instruction and occupies the upper half,
  // matching the local-store read data layout.
  typedef struct packed {
    logic [31:0] slot0;
    logic [31:0] slot1;
  } instr_pair_t;

  localparam instr_pair_t BUBBLE_PAIR = '{slot0: SPU_NOP, slot1: SPU_LNOP};

endpackage

// File: rtl/spu_fetch_skid.sv
// One-entry skid buffer holding an instruction pair and its post-increment PC
// while the fetch output register is stalled. Flush beats load beats drain.
module spu_fetch_skid
  import spu_pkg::*;
#(
  parameter int unsigned PCbitsize = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_drain,
  input  logic                 i_flush,
  input  logic [63:0]          i_pair,
  input  logic [PCbitsize-1:0] i_pcn,
  output logic                 o_valid,
  output logic [63:0]          o_pair,
  output logic [PCbitsize-1:0] o_pcn
);

  logic                 r_valid;
  instr_pair_t          r_pair;
  logic [PCbitsize-1:0] r_pcn;

  // Capture a pair when the output cannot take it; release it on drain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_pair  <= BUBBLE_PAIR;
      r_pcn   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pair  <= instr_pair_t'(i_pair);
      r_pcn   <= i_pcn;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pair  = r_pair;
  assign o_pcn   = r_pcn;

endmodule

// File: rtl/spu_fetch_unit.sv
// SPU instruction-fetch stage: holds the fetch PC, issues one 64-bit read per
// request to local store and presents the returned pair to IF/ID, with a
// one-entry skid buffer for decode stalls and branch redirect/squash.
// Optional: define SPU_FETCH_PERF_EN to add perf_stall_cnt / perf_flush_cnt.
module spu_fetch_unit
  import spu_pkg::*;
#(
  parameter int unsigned          PCbitsize = 32,
  parameter int unsigned          LS_ADDR_W = 18,
  parameter logic [PCbitsize-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_i,
  input  logic                 branch_taken,
  input  logic [PCbitsize-1:0] branch_target,
  output logic                 imem_req,
  output logic [LS_ADDR_W-1:0] imem_addr,
  input  logic                 imem_valid,
  input  logic [63:0]          imem_rdata,
  output logic [31:0]          instruction1,
  output logic [31:0]          instruction2,
  output logic [PCbitsize-1:0] PC_adderOut,
  output logic                 fetch_valid
`ifdef SPU_FETCH_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  localparam logic [LS_ADDR_W-1:0] PC_STEP    = LS_ADDR_W'(8);
  localparam logic [LS_ADDR_W-1:0] RESET_ADDR = RESET_PC[LS_ADDR_W-1:0] & ~LS_ADDR_W'(7);

  fetch_state_t         r_state, w_state_nxt;
  logic [LS_ADDR_W-1:0] r_pc;
  logic [LS_ADDR_W-1:0] r_req_pc;
  logic                 r_out_valid;
  instr_pair_t          r_out_pair;
  logic [PCbitsize-1:0] r_out_pcn;

  logic                 w_consume;
  logic                 w_out_free;
  logic                 w_ret;
  logic                 w_issue;
  logic                 w_skid_valid;
  logic                 w_skid_load;
  logic                 w_skid_drain;
  logic                 w_ret_to_out;
  logic [LS_ADDR_W-1:0] w_ret_sum;
  logic [PCbitsize-1:0] w_ret_pcn;
  logic [63:0]          w_skid_pair;
  logic [PCbitsize-1:0] w_skid_pcn;
  logic                 w_unused_target;

  // Only bits [LS_ADDR_W-1:3] of the redirect address are meaningful.
  assign w_unused_target = ^branch_target;

  // Handshake qualifiers and data-path steering for this cycle.
  always_comb begin
    w_consume    = r_out_valid & ~stall_i;
    w_out_free   = ~r_out_valid | w_consume;
    w_ret        = (r_state == S_WAIT) & imem_valid;
    w_issue      = reset & ~branch_taken & ~w_skid_valid & w_out_free &
                   ((r_state == S_IDLE) | w_ret);
    w_skid_drain = ~branch_taken & w_skid_valid & w_out_free;
    w_ret_to_out = ~branch_taken & ~w_skid_valid & w_ret & w_out_free;
    w_skid_load  = ~branch_taken & w_ret & ~w_out_free;
    w_ret_sum    = r_req_pc + PC_STEP;
    w_ret_pcn    = PCbitsize'(w_ret_sum);
  end

  // Next-state and output decode.
  // A return landing in S_DROP always retires the drop, even alongside a
  // redirect, since no further return will arrive for that request.
  always_comb begin
    w_state_nxt  = r_state;
    imem_req     = w_issue;
    imem_addr    = r_pc;
    fetch_valid  = r_out_valid;
    instruction1 = r_out_valid ? r_out_pair.slot0 : SPU_NOP;
    instruction2 = r_out_valid ? r_out_pair.slot1 : SPU_LNOP;
    PC_adderOut  = r_out_pcn;
    case (r_state)
      S_IDLE: if (w_issue) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_valid)        w_state_nxt = w_issue ? S_WAIT : S_IDLE;
        else if (branch_taken) w_state_nxt = S_DROP;
      end
      S_DROP: if (imem_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Fetch PC: redirect wins, otherwise advance by one pair per issue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc     <= RESET_ADDR;
      r_req_pc <= '0;
    end else if (branch_taken) begin
      r_pc <= {branch_target[LS_ADDR_W-1:3], 3'b000};
    end else if (w_issue) begin
      r_pc     <= r_pc + PC_STEP;
      r_req_pc <= r_pc;
    end
  end

  // Output register: skid drains first, then a fresh return, else consume.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_pair  <= BUBBLE_PAIR;
      r_out_pcn   <= '0;
    end else if (branch_taken) begin
      r_out_valid <= 1'b0;
    end else if (w_skid_drain) begin
      r_out_valid <= 1'b1;
      r_out_pair  <= instr_pair_t'(w_skid_pair);
      r_out_pcn   <= w_skid_pcn;
    end else if (w_ret_to_out) begin
      r_out_valid <= 1'b1;
      r_out_pair  <= instr_pair_t'(imem_rdata);
      r_out_pcn   <= w_ret_pcn;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  spu_fetch_skid #(
    .PCbitsize (PCbitsize)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_flush (branch_taken),
    .i_pair  (imem_rdata),
    .i_pcn   (w_ret_pcn),
    .o_valid (w_skid_valid),
    .o_pair  (w_skid_pair),
    .o_pcn   (w_skid_pcn)
  );

`ifdef SPU_FETCH_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Saturating event counters: stalled valid cycles and redirect pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (r_out_valid && stall_i && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (branch_taken && (r_perf_flush != '1))           r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_spu_fetch_unit.sv
// Bench for spu_fetch_unit: a driver process plays decode (stall/branch) and
// local store (random latency); a monitor process holds the expected pair
// stream in a queue and checks every presented output and every request.
module tb_spu_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0003_FFFC;
  localparam logic [17:0] RST_A  = 18'h3FFF8;
  localparam logic [31:0] NOP    = 32'h4020_0000;
  localparam logic [31:0] LNOP   = 32'h0020_0000;
  localparam logic [63:0] STALE  = 64'hDEAD_BEEF_CAFE_F00D;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [17:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [63:0] imem_rdata = '0;
  logic [31:0] instruction1, instruction2, PC_adderOut;
  logic        fetch_valid;

  always #5 clk = ~clk;

  spu_fetch_unit #(
    .PCbitsize (32),
    .LS_ADDR_W (18),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .instruction1  (instruction1),
    .instruction2  (instruction2),
    .PC_adderOut   (PC_adderOut),
    .fetch_valid   (fetch_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Local-store contents: a distinct pair per 8-byte address.
  function automatic logic [63:0] mem_data(input logic [17:0] a);
    logic [31:0] w;
    w = {14'd0, a};
    return {32'h1000_0000 | w, 32'h2ABC_0000 ^ (w * 32'd3)};
  endfunction

  // ---------------- reference model / monitor ----------------
  logic [17:0] exp_q[$];
  logic [17:0] q_next;
  logic [17:0] exp_req;
  logic [31:0] last_pcn;
  bit          prev_rst_low = 1'b0;
  int          n_consumed = 0;

  function automatic void reseed(input logic [17:0] a);
    exp_q.delete();
    q_next = a;
  endfunction

  initial begin
    logic [17:0] a, n, t;
    logic [63:0] d;
    exp_req  = RST_A;
    last_pcn = '0;
    reseed(RST_A);
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (prev_rst_low) begin
          check("rst_req", imem_req, 0);
          check("rst_fv", fetch_valid, 0);
          check("rst_i1", instruction1, NOP);
          check("rst_i2", instruction2, LNOP);
          check("rst_pcn", PC_adderOut, 0);
        end
        prev_rst_low = 1'b1;
        exp_req  = RST_A;
        last_pcn = '0;
        reseed(RST_A);
      end else begin
        prev_rst_low = 1'b0;
        while (exp_q.size() < 4) begin
          exp_q.push_back(q_next);
          q_next = q_next + 18'd8;
        end
        if (fetch_valid) begin
          a = exp_q[0];
          d = mem_data(a);
          n = a + 18'd8;
          check("pair_i1", instruction1, d[63:32]);
          check("pair_i2", instruction2, d[31:0]);
          check("pair_pcn", PC_adderOut, {14'd0, n});
          last_pcn = {14'd0, n};
        end else begin
          check("bubble_i1", instruction1, NOP);
          check("bubble_i2", instruction2, LNOP);
          check("bubble_pcn_hold", PC_adderOut, last_pcn);
        end
        if (imem_req) begin
          check("req_addr", imem_addr, exp_req);
          check("req_during_branch", branch_taken, 0);
          exp_req = exp_req + 18'd8;
        end
        if (fetch_valid && !stall_i && !branch_taken) begin
          void'(exp_q.pop_front());
          n_consumed++;
        end
        if (branch_taken) begin
          t = {branch_target[17:3], 3'b000};
          reseed(t);
          exp_req = t;
        end
      end
    end
  end

  // ---------------- driver + memory ----------------
  int          lat_min = 1;
  int          lat_max = 1;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [17:0] mem_addr = '0;
  bit          inject_stale = 1'b0;
  logic        rst_next = 1'b0;

  task automatic cycle(input bit stl, input bit br, input logic [31:0] tgt);
    @(negedge clk);
    reset         = rst_next;
    stall_i       = stl;
    branch_taken  = br;
    branch_target = tgt;
    imem_valid    = 1'b0;
    imem_rdata    = '0;
    if (inject_stale) begin
      imem_valid   = 1'b1;
      imem_rdata   = STALE;
      inject_stale = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_data(mem_addr);
        mem_busy   = 1'b0;
      end
    end
    #1;
    if (!reset) begin
      mem_busy = 1'b0;
    end else if (imem_req) begin
      check("one_outstanding", mem_busy, 0);
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min);
    end
  endtask

  task automatic wait_req(input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(0, 0, 32'd0);
      if (imem_req) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    bit seen;

    // Reset held, then release: first request goes to the (aligned) reset PC.
    rst_next = 1'b0;
    repeat (3) cycle(0, 0, 32'd0);
    rst_next = 1'b1;
    cycle(0, 0, 32'd0);
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, RST_A);

    // 1-cycle memory: second request wraps to 0, then one pair per cycle.
    cycle(0, 0, 32'd0);
    check("t5_wrap_req", imem_req, 1);
    check("t5_wrap_addr", imem_addr, 0);
    cycle(0, 0, 32'd0);
    check("t5_first_pcn", PC_adderOut, 0);
    for (int i = 0; i < 20; i++) begin
      check("t2_stream_fv", fetch_valid, 1);
      cycle(0, 0, 32'd0);
    end

    // Decode stall: output and skid fill, no further requests.
    repeat (6) cycle(1, 0, 32'd0);
    check("t3_req_held", imem_req, 0);
    check("t3_fv_held", fetch_valid, 1);
    repeat (10) cycle(0, 0, 32'd0);

    // 3-cycle memory, redirect one cycle after a request.
    lat_min = 3;
    lat_max = 3;
    wait_req("t4_req_seen", seen);
    cycle(0, 1, 32'h0000_1234);
    wait_req("t4_redirect_req_seen", seen);
    check("t4_redirect_addr", imem_addr, 18'h1230);
    repeat (10) cycle(0, 0, 32'd0);

    // Randomized traffic.
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 3, $urandom);
    end
    branch_taken = 1'b0;

    // Reset with a request outstanding; stale return arrives as reset releases.
    lat_min = 3;
    lat_max = 3;
    wait_req("t6_req_seen", seen);
    rst_next = 1'b0;
    repeat (3) cycle(0, 0, 32'd0);
    rst_next     = 1'b1;
    inject_stale = 1'b1;
    cycle(0, 0, 32'd0);
    check("t6_req", imem_req, 1);
    check("t6_addr", imem_addr, RST_A);
    lat_min = 1;
    lat_max = 2;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 0, 32'd0);
      if (fetch_valid) seen = 1'b1;
    end
    check("t6_progress", seen, 1);
    check("overall_progress", n_consumed > 500, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
